sram_mem_ctrl: RTL and testbench
================================

Name: sram_mem_ctrl

Overview:
- Memory-side consumer of the EXE-stage request signals (mem_read_en, mem_write_en, alu_res as address, val_Rm as store data), after they pass through the EXE/MEM register.
- Turns one 32-bit load/store into two sequential 16-bit accesses on an external asynchronous SRAM.
- Drives `ready` low while busy; the hazard/freeze logic stalls all pipeline registers on !ready.
- Returns the assembled 32-bit load word to the MEM/WB register.

Parameters:
ADDR_BASE, 1024, byte address of data memory word 0; subtracted from the incoming address.
WAIT_CYCLES, 5, cycles each 16-bit SRAM access is held; legal range 1..15.
SRAM_AW, 18, SRAM address width in halfwords.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
rd_en  in  1  load request, held stable until ready=1
wr_en  in  1  store request, held stable until ready=1
address  in  32  byte address (ALU result)
write_data  in  32  store data (val_Rm)
read_data  out  32  load result, valid while ready=1 after a load
ready  out  1  0 = freeze pipeline
sram_addr  out  SRAM_AW  halfword address
sram_dq_out  out  16  write data to SRAM
sram_dq_in  in  16  read data from SRAM
sram_dq_oe  out  1  1 = controller drives data bus
sram_we_n  out  1  active-low write strobe

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address map:
  - off = address - ADDR_BASE, computed in 32 bits, modulo 2^32.
  - widx = off[SRAM_AW:2]; off[1:0] is ignored.
  - Low half at sram_addr = {widx,1'b0}; high half at {widx,1'b1}.
  - Out-of-range addresses wrap silently; there is no error signal.
- FSM states: IDLE, ACC_LO, ACC_HI, DONE.
- IDLE:
  - ready = !(rd_en|wr_en), combinational, so freeze asserts in the same cycle a request appears.
  - On request: latch address, write_data and op (wr_en has priority if both are high); counter=0; go to ACC_LO.
- ACC_LO:
  - sram_addr = low half address.
  - On a store: sram_dq_oe=1, sram_dq_out=wdata[15:0], sram_we_n=0.
  - On a load: sram_we_n=1, sram_dq_oe=0.
  - Counter increments each cycle. At count WAIT_CYCLES-1: a load captures sram_dq_in into read_data[15:0]; counter resets to 0; go to ACC_HI.
- ACC_HI:
  - Same as ACC_LO, using the high half address and wdata[31:16] / read_data[31:16].
  - At count WAIT_CYCLES-1, go to DONE.
- DONE:
  - ready=1 for exactly one cycle; sram_we_n=1; sram_dq_oe=0.
  - Next state is IDLE unconditionally. The pipeline advances on this edge; a new request is evaluated in the following IDLE cycle.
- Strobe timing: sram_we_n returns to 1 and sram_dq_oe returns to 0 on the first cycle outside the ACC states. sram_addr holds its last value until the next access.
- Latency: request seen in cycle 0; ACC_LO occupies cycles 1..W; ACC_HI occupies W+1..2W; DONE is cycle 2W+1. Freeze lasts 2W+1 cycles (11 at default W).
- read_data: updated only by loads; holds its value across stores and idle.
- Request dropped mid-access (protocol violation): the access completes using the latched values.
- rst_n low mid-access: at that edge the state returns to IDLE and outputs take reset values. A partial write is abandoned and the half already written remains in SRAM.

Decomposition:
- Shared package mem_pkg: state enum (IDLE, ACC_LO, ACC_HI, DONE), ADDR_BASE default, SRAM data width constant 16.
- One sub-module, sram_wait_counter: ports clk, rst_n, clear, en, out `last` (count==WAIT_CYCLES-1). It is reused by the ACC_LO and ACC_HI phases.

Test Plan:
- Store: wr_en, address=0x0000_0400, write_data=0xDEADBEEF, W=5 -> SRAM addr 0 gets 0xBEEF (we_n low cycles 1..5), addr 1 gets 0xDEAD (cycles 6..10); ready=0 cycles 0..10, ready=1 cycle 11.
- Load-back: rd_en, address=0x400 with the SRAM model holding the above -> read_data=0xDEADBEEF at cycle 11; sram_we_n stays 1 and sram_dq_oe stays 0 throughout.
- Mapping: store to address 0x0000_040C -> halfword addrs 6 and 7. Address 0x0000_040E behaves identically (low bits ignored).
- Idle/back-to-back: no request -> ready=1 every cycle. Two loads held back-to-back -> second access starts at the IDLE cycle after DONE, and ready pulses exactly once per access.
- Reset mid-store: rst_n=0 sampled at cycle 3 of a store -> next cycle state IDLE, we_n=1, dq_oe=0, read_data=0. After rst_n=1 with no request, ready=1.
- WAIT_CYCLES=1: load at 0x404 -> ACC_LO cycle 1, ACC_HI cycle 2, ready=1 cycle 3 with the correct word.

Source files
------------

// File: rtl/sram_mem_ctrl_pkg.sv
// ============================================================================
// mem_pkg: shared FSM state type and constants for sram_mem_ctrl. Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;
  localparam int unsigned SRAM_DW       = 16;

endpackage

`default_nettype wire

// File: rtl/sram_mem_ctrl_if.sv
// ============================================================================
// sram_mem_ctrl_if: pipeline-side load/store request bus. Rev 1.0
// ============================================================================
`default_nettype none

interface sram_mem_ctrl_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );

endinterface

`default_nettype wire

// File: rtl/sram_mem_ctrl_wait_counter.sv
// ============================================================================
// sram_wait_counter: per-halfword access timer, flags the final hold cycle. Rev 1.0
// ============================================================================
`default_nettype none

module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  logic [3:0] r_count;

  assign last = (r_count == 4'(WAIT_CYCLES - 1));

  // Wraps to zero on its own so the same counter times both halves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (clear) begin
      r_count <= 4'd0;
    end else if (en) begin
      r_count <= last ? 4'd0 : r_count + 4'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_mem_ctrl.sv
// ============================================================================
// sram_mem_ctrl: splits each 32-bit load/store into two 16-bit async SRAM accesses. Rev 1.0
// ============================================================================
`default_nettype none

module sram_mem_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_mem_ctrl_if.slave     bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  state_t r_state;
  state_t w_next;

  logic               w_req;
  logic               w_last;
  logic               w_in_acc;
  logic [31:0]        w_off;
  logic               w_unused;

  logic               r_is_wr;
  logic [SRAM_AW-2:0] r_widx;
  logic [31:0]        r_wdata;

  logic               w_lat_is_wr;
  logic [SRAM_AW-2:0] w_lat_widx;
  logic [31:0]        w_lat_wdata;

  logic [SRAM_AW-1:0] r_sram_addr;
  logic [SRAM_DW-1:0] r_dq_out;
  logic               r_dq_oe;
  logic               r_we_n;
  logic [31:0]        r_read_data;

  logic [SRAM_AW-1:0] w_addr_nxt;
  logic [SRAM_DW-1:0] w_dq_out_nxt;
  logic               w_dq_oe_nxt;
  logic               w_we_n_nxt;
  logic [31:0]        w_read_data_nxt;
  logic               w_ready;

  assign w_req    = bus.rd_en | bus.wr_en;
  assign w_in_acc = (r_state == ACC_LO) || (r_state == ACC_HI);
  assign w_off    = bus.address - ADDR_BASE;
  assign w_unused = &{1'b0, w_off[31:SRAM_AW+1], w_off[1:0]};

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (r_state == IDLE),
    .en    (w_in_acc),
    .last  (w_last)
  );

  // Request fields are latched only in IDLE, so a dropped request mid-access
  // still completes with the original address and data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_wr <= 1'b0;
      r_widx  <= '0;
      r_wdata <= 32'd0;
    end else if (r_state == IDLE) begin
      r_is_wr <= bus.wr_en;
      r_widx  <= w_off[SRAM_AW:2];
      r_wdata <= bus.write_data;
    end
  end

  // On the IDLE->ACC_LO edge the latches are not yet loaded, so use the bus.
  assign w_lat_is_wr = (r_state == IDLE) ? bus.wr_en         : r_is_wr;
  assign w_lat_widx  = (r_state == IDLE) ? w_off[SRAM_AW:2]  : r_widx;
  assign w_lat_wdata = (r_state == IDLE) ? bus.write_data    : r_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req)  w_next = ACC_LO;
      ACC_LO:  if (w_last) w_next = ACC_HI;
      ACC_HI:  if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // SRAM pins are registered from the next state so strobes line up exactly
  // with the ACC cycles and drop on the first cycle after them.
  always_comb begin
    w_addr_nxt      = r_sram_addr;
    w_dq_out_nxt    = r_dq_out;
    w_dq_oe_nxt     = 1'b0;
    w_we_n_nxt      = 1'b1;
    w_read_data_nxt = r_read_data;
    w_ready         = 1'b0;

    case (r_state)
      IDLE:    w_ready = !w_req;
      DONE:    w_ready = 1'b1;
      default: w_ready = 1'b0;
    endcase

    case (w_next)
      ACC_LO: begin
        w_addr_nxt = {w_lat_widx, 1'b0};
        if (w_lat_is_wr) begin
          w_dq_out_nxt = w_lat_wdata[15:0];
          w_dq_oe_nxt  = 1'b1;
          w_we_n_nxt   = 1'b0;
        end
      end
      ACC_HI: begin
        w_addr_nxt = {w_lat_widx, 1'b1};
        if (w_lat_is_wr) begin
          w_dq_out_nxt = w_lat_wdata[31:16];
          w_dq_oe_nxt  = 1'b1;
          w_we_n_nxt   = 1'b0;
        end
      end
      default: ;
    endcase

    if (!r_is_wr && w_last) begin
      if (r_state == ACC_LO) begin
        w_read_data_nxt[15:0] = sram_dq_in;
      end else if (r_state == ACC_HI) begin
        w_read_data_nxt[31:16] = sram_dq_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_read_data <= 32'd0;
    end else begin
      r_sram_addr <= w_addr_nxt;
      r_dq_out    <= w_dq_out_nxt;
      r_dq_oe     <= w_dq_oe_nxt;
      r_we_n      <= w_we_n_nxt;
      r_read_data <= w_read_data_nxt;
    end
  end

  assign sram_addr     = r_sram_addr;
  assign sram_dq_out   = r_dq_out;
  assign sram_dq_oe    = r_dq_oe;
  assign sram_we_n     = r_we_n;
  assign bus.read_data = r_read_data;
  assign bus.ready     = w_ready;

endmodule

`default_nettype wire

// File: tb/tb_sram_mem_ctrl.sv
// ============================================================================
// tb_sram_mem_ctrl: scoreboard bench, W=5 and W=1 controllers on behavioural SRAMs. Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_mem_ctrl;

  localparam int W0 = 5;
  localparam int W1 = 1;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  sram_mem_ctrl_if bus0 ();
  sram_mem_ctrl_if bus1 ();

  logic [17:0] sram_addr0, sram_addr1;
  logic [15:0] dq_out0, dq_out1, dq_in0, dq_in1;
  logic        dq_oe0, dq_oe1, we_n0, we_n1;
  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];

  sram_mem_ctrl #(.WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .sram_addr(sram_addr0), .sram_dq_out(dq_out0), .sram_dq_in(dq_in0),
    .sram_dq_oe(dq_oe0), .sram_we_n(we_n0)
  );

  sram_mem_ctrl #(.WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1),
    .sram_dq_oe(dq_oe1), .sram_we_n(we_n1)
  );

  // Behavioural async SRAMs: combinational read, write while we_n is low.
  assign dq_in0 = mem0[sram_addr0[7:0]];
  assign dq_in1 = mem1[sram_addr1[7:0]];
  always @(posedge clk) if (we_n0 === 1'b0 && dq_oe0 === 1'b1) mem0[sram_addr0[7:0]] <= dq_out0;
  always @(posedge clk) if (we_n1 === 1'b0 && dq_oe1 === 1'b1) mem1[sram_addr1[7:0]] <= dq_out1;

  int   tests = 0;
  int   fails = 0;
  bit   mute;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic prev_rdy0, prev_rdy1;
  int   we_cnt0, oe_cnt0, first_we0, last_we0;
  int   st;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: every ready rise (end of an access) pops one expected response.
  always @(negedge clk) begin
    if (!mute && prev_rdy0 === 1'b0 && bus0.ready === 1'b1) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done0: got ready pulse, expected none");
      end else begin
        e0 = q0.pop_front();
        check("done_cycle0", 32'(cyc), 32'(e0.done_cyc));
        if (e0.is_load) check("load_data0", bus0.read_data, e0.data);
      end
    end
    prev_rdy0 = bus0.ready;
  end

  always @(negedge clk) begin
    if (!mute && prev_rdy1 === 1'b0 && bus1.ready === 1'b1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done1: got ready pulse, expected none");
      end else begin
        e1 = q1.pop_front();
        check("done_cycle1", 32'(cyc), 32'(e1.done_cyc));
        if (e1.is_load) check("load_data1", bus1.read_data, e1.data);
      end
    end
    prev_rdy1 = bus1.ready;
  end

  always @(negedge clk) begin
    if (we_n0 === 1'b0) begin
      if (we_cnt0 == 0) first_we0 = cyc;
      last_we0 = cyc;
      we_cnt0++;
    end
    if (dq_oe0 === 1'b1) oe_cnt0++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr0();
    we_cnt0 = 0; oe_cnt0 = 0; first_we0 = -1; last_we0 = -1;
  endtask

  task automatic issue0(bit wr, logic [31:0] a, logic [31:0] d, bit push, logic [31:0] exp);
    bus0.wr_en = wr; bus0.rd_en = !wr; bus0.address = a; bus0.write_data = d;
    if (push) q0.push_back('{!wr, exp, cyc + 2 * W0 + 1});
  endtask

  task automatic issue1(bit wr, logic [31:0] a, logic [31:0] d, bit push, logic [31:0] exp);
    bus1.wr_en = wr; bus1.rd_en = !wr; bus1.address = a; bus1.write_data = d;
    if (push) q1.push_back('{!wr, exp, cyc + 2 * W1 + 1});
  endtask

  task automatic idle0();
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0;
  endtask

  task automatic idle1();
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0;
  endtask

  task automatic wait_done0();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus0.ready === 1'b1) return;
    end
    tests++; fails++;
    $display("FAIL timeout0: ready stayed 0, expected 1 within 64 cycles");
  endtask

  task automatic wait_done1();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus1.ready === 1'b1) return;
    end
    tests++; fails++;
    $display("FAIL timeout1: ready stayed 0, expected 1 within 64 cycles");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mute = 1'b1;
    rst_n = 1'b0;
    bus0.rd_en = 0; bus0.wr_en = 0; bus0.address = 0; bus0.write_data = 0;
    bus1.rd_en = 0; bus1.wr_en = 0; bus1.address = 0; bus1.write_data = 0;
    clr0();
    repeat (3) @(posedge clk);

    @(negedge clk);
    check("rst_ready",     32'(bus0.ready), 32'd1);
    check("rst_we_n",      32'(we_n0), 32'd1);
    check("rst_dq_oe",     32'(dq_oe0), 32'd0);
    check("rst_read_data", bus0.read_data, 32'd0);
    check("rst_sram_addr", 32'(sram_addr0), 32'd0);
    check("rst_dq_out",    32'(dq_out0), 32'd0);
    step(); rst_n = 1'b1;
    step(); mute = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(bus0.ready), 32'd1);
    end

    // Store 0xDEADBEEF at 0x400 -> halfwords 0 and 1
    step(); clr0(); st = cyc;
    issue0(1'b1, 32'h400, 32'hDEADBEEF, 1'b1, 32'h0);
    @(negedge clk);
    check("freeze_same_cycle", 32'(bus0.ready), 32'd0);
    wait_done0();
    check("store_we_cycles", 32'(we_cnt0), 32'd10);
    check("store_oe_cycles", 32'(oe_cnt0), 32'd10);
    check("store_we_first",  32'(first_we0), 32'(st + 1));
    check("store_we_last",   32'(last_we0), 32'(st + 10));
    step(); idle0();
    @(negedge clk);
    check("store_mem0", {16'h0, mem0[0]}, 32'h0000BEEF);
    check("store_mem1", {16'h0, mem0[1]}, 32'h0000DEAD);

    // Load back, no write strobes expected
    step(); clr0();
    issue0(1'b0, 32'h400, 32'h0, 1'b1, 32'hDEADBEEF);
    wait_done0();
    check("load_no_we", 32'(we_cnt0), 32'd0);
    check("load_no_oe", 32'(oe_cnt0), 32'd0);
    step(); idle0();

    // Mapping: 0x40C and 0x40E both hit halfwords 6/7
    step();
    issue0(1'b1, 32'h40C, 32'h12345678, 1'b1, 32'h0);
    wait_done0();
    step(); idle0();
    @(negedge clk);
    check("map_40c_lo", {16'h0, mem0[6]}, 32'h00005678);
    check("map_40c_hi", {16'h0, mem0[7]}, 32'h00001234);
    check("rdata_hold_store", bus0.read_data, 32'hDEADBEEF);
    step();
    issue0(1'b1, 32'h40E, 32'hCAFEF00D, 1'b1, 32'h0);
    wait_done0();
    step(); idle0();
    @(negedge clk);
    check("map_40e_lo", {16'h0, mem0[6]}, 32'h0000F00D);
    check("map_40e_hi", {16'h0, mem0[7]}, 32'h0000CAFE);

    // Back-to-back loads, request held through DONE
    step();
    issue0(1'b0, 32'h400, 32'h0, 1'b1, 32'hDEADBEEF);
    wait_done0();
    step();
    issue0(1'b0, 32'h40C, 32'h0, 1'b1, 32'hCAFEF00D);
    @(negedge clk);
    check("b2b_idle_freeze", 32'(bus0.ready), 32'd0);
    wait_done0();
    step(); idle0();

    // Reset sampled at cycle 3 of a store
    step(); clr0(); mute = 1'b1; st = cyc;
    issue0(1'b1, 32'h400, 32'h11112222, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0; idle0();
    @(posedge clk);
    @(negedge clk);
    check("rstmid_we_n",   32'(we_n0), 32'd1);
    check("rstmid_dq_oe",  32'(dq_oe0), 32'd0);
    check("rstmid_rdata",  bus0.read_data, 32'd0);
    check("rstmid_we_cnt", 32'(we_cnt0), 32'd3);
    step(); rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_ready", 32'(bus0.ready), 32'd1);
    check("rstmid_mem_lo", {16'h0, mem0[0]}, 32'h00002222);
    check("rstmid_mem_hi", {16'h0, mem0[1]}, 32'h0000DEAD);
    step(); mute = 1'b0;

    // WAIT_CYCLES=1 instance: store then load at 0x404 (halfwords 2/3)
    step();
    issue1(1'b1, 32'h404, 32'hA5A53C3C, 1'b1, 32'h0);
    wait_done1();
    step(); idle1();
    @(negedge clk);
    check("w1_mem_lo", {16'h0, mem1[2]}, 32'h00003C3C);
    check("w1_mem_hi", {16'h0, mem1[3]}, 32'h0000A5A5);
    step();
    issue1(1'b0, 32'h404, 32'h0, 1'b1, 32'hA5A53C3C);
    wait_done1();
    step(); idle1();

    repeat (2) step();
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
